// File: rtl/pong_responder.sv
// Responder side of the ping/pong handshake: answers each accepted ping with a
// one-cycle pong DELAY cycles later, counts rallies and flags done after ROUNDS.
module pong_responder #(
  parameter int unsigned DELAY  = 1,
  parameter int unsigned ROUNDS = 10,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ping,
  input  logic             clear,
  output logic             pong,
  output logic             busy,
  output logic [CNT_W-1:0] rounds,
  output logic             done,
  output logic             overrun
);

  localparam int unsigned     DW    = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [DW-1:0]   DLOAD = DW'(DELAY - 1);
  localparam logic [CNT_W-1:0] RMAX = CNT_W'(ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic             pong_q, pong_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] rounds_q, rounds_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] rounds_inc;

  assign rounds_inc = rounds_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pong_q    <= 1'b0;
      busy_q    <= 1'b0;
      rounds_q  <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pong_q    <= pong_d;
      busy_q    <= busy_d;
      rounds_q  <= rounds_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (ping) state_d = S_WAIT;
        S_WAIT: if (cnt_q == '0) state_d = (rounds_inc == RMAX) ? S_DONE : S_IDLE;
        S_DONE: state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Registered-output next values; clear wins over any ping on the same edge.
  always_comb begin
    cnt_d     = cnt_q;
    pong_d    = 1'b0;
    busy_d    = busy_q;
    rounds_d  = rounds_q;
    done_d    = done_q;
    overrun_d = overrun_q;
    if (clear) begin
      cnt_d     = '0;
      busy_d    = 1'b0;
      rounds_d  = '0;
      done_d    = 1'b0;
      overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (ping) begin
            cnt_d  = DLOAD;
            busy_d = 1'b1;
          end
        end
        S_WAIT: begin
          if (ping) overrun_d = 1'b1;
          if (cnt_q == '0) begin
            pong_d   = 1'b1;
            busy_d   = 1'b0;
            rounds_d = rounds_inc;
            done_d   = (rounds_inc == RMAX);
          end else begin
            cnt_d = cnt_q - DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign pong    = pong_q;
  assign busy    = busy_q;
  assign rounds  = rounds_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule
